// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU issue path: ALU control codes,
// funct3 encodings and the decoded issue payload.
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [CODE_W-1:0] {
        ALU_EQU = 4'b0000,
        ALU_LT  = 4'b0001,
        ALU_LTU = 4'b0010,
        ALU_GT  = 4'b0011,
        ALU_GTU = 4'b0100,
        ALU_ADD = 4'b0101,
        ALU_SUB = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_OR  = 4'b1011,
        ALU_XOR = 4'b1100,
        ALU_AND = 4'b1101
    } alu_code_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        alu_code_e       code;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            sel_cmp;
        logic            inv_taken;
        logic            flags_en;
        logic            illegal;
        logic            is_branch;
    } alu_issue_t;

    localparam alu_issue_t ISSUE_RST = '{
        code:      ALU_ADD,
        a:         '0,
        b:         '0,
        sel_cmp:   1'b0,
        inv_taken: 1'b0,
        flags_en:  1'b0,
        illegal:   1'b0,
        is_branch: 1'b0
    };

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of OP / OP-IMM / BRANCH fields into an ALU issue payload.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic            is_branch,
    input  logic            is_imm,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output alu_issue_t      issue_c
);

    logic reg_f7_bad_c;

    assign reg_f7_bad_c = !is_imm && funct7_b5;

    always_comb begin
        issue_c           = ISSUE_RST;
        issue_c.a         = rs1;
        issue_c.b         = (is_imm && !is_branch) ? imm : rs2;
        issue_c.is_branch = is_branch;

        if (is_branch) begin
            unique case (funct3)
                F3_BEQ:  issue_c.code = ALU_EQU;
                F3_BNE:  begin issue_c.code = ALU_EQU; issue_c.inv_taken = 1'b1; end
                F3_BLT:  issue_c.code = ALU_LT;
                F3_BGE:  begin issue_c.code = ALU_LT;  issue_c.inv_taken = 1'b1; end
                F3_BLTU: issue_c.code = ALU_LTU;
                F3_BGEU: begin issue_c.code = ALU_LTU; issue_c.inv_taken = 1'b1; end
                default: issue_c.illegal = 1'b1;
            endcase
        end else begin
            unique case (funct3)
                F3_ADD: begin
                    issue_c.code     = reg_f7_bad_c ? ALU_SUB : ALU_ADD;
                    issue_c.flags_en = 1'b1;
                end
                F3_SLL: begin
                    issue_c.code    = ALU_SLL;
                    issue_c.illegal = funct7_b5;
                end
                F3_SLT: begin
                    issue_c.code    = ALU_LT;
                    issue_c.sel_cmp = 1'b1;
                    issue_c.illegal = reg_f7_bad_c;
                end
                F3_SLTU: begin
                    issue_c.code    = ALU_LTU;
                    issue_c.sel_cmp = 1'b1;
                    issue_c.illegal = reg_f7_bad_c;
                end
                F3_XOR: begin
                    issue_c.code    = ALU_XOR;
                    issue_c.illegal = reg_f7_bad_c;
                end
                F3_SR:   issue_c.code = funct7_b5 ? ALU_SRA : ALU_SRL;
                F3_OR: begin
                    issue_c.code    = ALU_OR;
                    issue_c.illegal = reg_f7_bad_c;
                end
                default: begin
                    issue_c.code    = ALU_AND;
                    issue_c.illegal = reg_f7_bad_c;
                end
            endcase
        end

        // Unsupported encodings issue a harmless ADD and retire with a zeroed result.
        if (issue_c.illegal) begin
            issue_c.code      = ALU_ADD;
            issue_c.sel_cmp   = 1'b0;
            issue_c.inv_taken = 1'b0;
            issue_c.flags_en  = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue/retire controller: decodes commands into an issue register
// that drives the ALU, then captures ALU results into a handshaked output register.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned BITS_SIZE  = XLEN,
    parameter int unsigned CNTRL_SIZE = CODE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_branch,
    input  logic                  in_is_imm,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_b5,
    input  logic [BITS_SIZE-1:0]  in_rs1,
    input  logic [BITS_SIZE-1:0]  in_rs2,
    input  logic [BITS_SIZE-1:0]  in_imm,
    output logic [BITS_SIZE-1:0]  alu_a,
    output logic [BITS_SIZE-1:0]  alu_b,
    output logic [CNTRL_SIZE-1:0] alu_cntrl,
    output logic                  alu_cin,
    input  logic [BITS_SIZE-1:0]  alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_ovf,
    input  logic                  alu_neg,
    input  logic                  alu_carry,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS_SIZE-1:0]  out_result,
    output logic [2:0]            out_flags,
    output logic                  out_is_branch,
    output logic                  out_taken,
    output logic                  out_illegal
);

    alu_issue_t dec_c;
    alu_issue_t s1;
    logic       s1_valid;
    logic       advance_c;

    alu_op_decode u_decode (
        .is_branch (in_is_branch),
        .is_imm    (in_is_imm),
        .funct3    (in_funct3),
        .funct7_b5 (in_funct7_b5),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .imm       (in_imm),
        .issue_c   (dec_c)
    );

    // No skid buffer: backpressure passes straight through to the command side.
    assign advance_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || advance_c;

    assign alu_a     = s1.a;
    assign alu_b     = s1.b;
    assign alu_cntrl = s1.code;
    assign alu_cin   = 1'b0;

    // Stage 1: issue register feeding the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= ISSUE_RST;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= dec_c;
            end
        end
    end

    // Stage 2: output register; branches and illegal ops retire a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_flags     <= 3'b0;
            out_is_branch <= 1'b0;
            out_taken     <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (advance_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                if (s1.illegal || s1.is_branch) begin
                    out_result <= '0;
                end else if (s1.sel_cmp) begin
                    out_result <= BITS_SIZE'(alu_zero);
                end else begin
                    out_result <= alu_out;
                end
                out_flags     <= s1.flags_en ? {alu_carry, alu_ovf, alu_neg} : 3'b0;
                out_is_branch <= s1.is_branch;
                out_taken     <= s1.is_branch && !s1.illegal && (alu_zero ^ s1.inv_taken);
                out_illegal   <= s1.illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, vector table, scoreboard and
// hand-written backpressure / reset sequences.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_is_branch, in_is_imm, in_funct7_b5;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_cntrl;
    logic        alu_cin, alu_zero, alu_ovf, alu_neg, alu_carry;
    logic        out_valid, out_ready, out_is_branch, out_taken, out_illegal;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_branch(in_is_branch), .in_is_imm(in_is_imm),
        .in_funct3(in_funct3), .in_funct7_b5(in_funct7_b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_neg(alu_neg), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .out_is_branch(out_is_branch), .out_taken(out_taken), .out_illegal(out_illegal)
    );

    // Behavioural ALU; carry/ovf are junk outside ADD/SUB so flag gating is visible.
    logic [32:0] sum;
    always_comb begin
        sum       = 33'd0;
        alu_out   = 32'd0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_cntrl)
            4'b0101, 4'b0110: begin
                sum     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = sum[31:0];
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            4'b0111: begin
                sum     = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out = sum[31:0];
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            4'b1000: alu_out = alu_a << alu_b[4:0];
            4'b1001: alu_out = alu_a >> alu_b[4:0];
            4'b1010: alu_out = 32'($signed(alu_a) >>> alu_b[4:0]);
            4'b1011: alu_out = alu_a | alu_b;
            4'b1100: alu_out = alu_a ^ alu_b;
            4'b1101: alu_out = alu_a & alu_b;
            default: alu_out = 32'hDEAD_BEEF;
        endcase
        if (alu_cntrl == 4'b0101 || alu_cntrl == 4'b0110 || alu_cntrl == 4'b0111) begin
            alu_carry = sum[32];
        end else begin
            alu_carry = alu_out[0];
            alu_ovf   = 1'b1;
        end
        alu_neg = alu_out[31];
        case (alu_cntrl)
            4'b0000: alu_zero = (alu_a == alu_b);
            4'b0001: alu_zero = ($signed(alu_a) < $signed(alu_b));
            4'b0010: alu_zero = (alu_a < alu_b);
            4'b0011: alu_zero = ($signed(alu_a) > $signed(alu_b));
            4'b0100: alu_zero = (alu_a > alu_b);
            default: alu_zero = (alu_out == 32'd0);
        endcase
    end

    typedef struct packed {
        logic        br;
        logic        im;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [3:0]  code;
        logic        chk_code;
        logic [31:0] res;
        logic [2:0]  flags;
        logic        taken;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [3:0]  code;
        logic        chk_code;
        logic [31:0] res;
        logic [2:0]  flags;
        logic        is_br;
        logic        taken;
        logic        ill;
        logic [7:0]  idx;
    } exp_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    exp_t sb[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    logic saw_stall = 1'b0;
    logic prev_adv  = 1'b0;
    logic [3:0] prev_cntrl = 4'd0;

    function automatic vec_t mk(input logic br, input logic im, input logic [2:0] f3,
                                input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [3:0] code, input logic chk,
                                input logic [31:0] res, input logic [2:0] flags,
                                input logic taken, input logic ill);
        vec_t v;
        v = '{br: br, im: im, f3: f3, f7: f7, rs1: rs1, rs2: rs2, imm: imm, code: code,
              chk_code: chk, res: res, flags: flags, taken: taken, ill: ill};
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s op%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic send(input vec_t v, input int idx, output int stalls);
        exp_t e;
        in_is_branch = v.br;
        in_is_imm    = v.im;
        in_funct3    = v.f3;
        in_funct7_b5 = v.f7;
        in_rs1       = v.rs1;
        in_rs2       = v.rs2;
        in_imm       = v.imm;
        in_valid     = 1'b1;
        stalls       = 0;
        @(negedge clk);
        while (!in_ready && stalls < 50) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", idx, 32'(in_ready), 32'd1);
        end else begin
            e = '{code: v.code, chk_code: v.chk_code, res: v.res, flags: v.flags,
                  is_br: v.br, taken: v.taken, ill: v.ill, idx: 8'(idx)};
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 0, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: a new output appears when out_valid is set after a cycle that allowed advance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_adv = 1'b0;
            end else begin
                if (out_valid && prev_adv) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        check("unexpected_output", n_out, 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_code) check("alu_cntrl", int'(e.idx), 32'(prev_cntrl), 32'(e.code));
                        check("out_result", int'(e.idx), out_result, e.res);
                        check("out_flags", int'(e.idx), 32'(out_flags), 32'(e.flags));
                        check("out_is_branch", int'(e.idx), 32'(out_is_branch), 32'(e.is_br));
                        check("out_taken", int'(e.idx), 32'(out_taken), 32'(e.taken));
                        check("out_illegal", int'(e.idx), 32'(out_illegal), 32'(e.ill));
                    end
                end
                if (in_valid && !in_ready) saw_stall = 1'b1;
                prev_adv   = !out_valid || out_ready;
                prev_cntrl = alu_cntrl;
            end
        end
    end

    initial begin
        int st;
        int tot;
        int out_before;

        //            br im f3     f7 rs1           rs2           imm           code   chk res           flg     tk  ill
        vecs[0]  = mk(0, 0, 3'b000, 1, 32'd5,        32'd7,        32'd0,        4'b0111, 1, 32'hFFFFFFFE, 3'b001, 0, 0);
        vecs[1]  = mk(0, 0, 3'b000, 0, 32'h7FFFFFFF, 32'd1,        32'd0,        4'b0101, 1, 32'h80000000, 3'b011, 0, 0);
        vecs[2]  = mk(0, 1, 3'b000, 1, 32'd1,        32'd9,        32'hFFFFFFFF, 4'b0101, 1, 32'h00000000, 3'b100, 0, 0);
        vecs[3]  = mk(0, 1, 3'b101, 1, 32'h80000000, 32'd0,        32'h00000404, 4'b1010, 1, 32'hF8000000, 3'b000, 0, 0);
        vecs[4]  = mk(0, 1, 3'b101, 0, 32'h80000000, 32'd0,        32'd4,        4'b1001, 1, 32'h08000000, 3'b000, 0, 0);
        vecs[5]  = mk(0, 0, 3'b001, 0, 32'd1,        32'h25,       32'd0,        4'b1000, 1, 32'h00000020, 3'b000, 0, 0);
        vecs[6]  = mk(0, 1, 3'b010, 0, 32'hFFFFFFFD, 32'd0,        32'd2,        4'b0001, 1, 32'h00000001, 3'b000, 0, 0);
        vecs[7]  = mk(0, 0, 3'b011, 0, 32'hFFFFFFFD, 32'd2,        32'd0,        4'b0010, 1, 32'h00000000, 3'b000, 0, 0);
        vecs[8]  = mk(0, 0, 3'b100, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        4'b1100, 1, 32'h0FF00FF0, 3'b000, 0, 0);
        vecs[9]  = mk(0, 0, 3'b110, 0, 32'hF0F0F0F0, 32'h0F0F0000, 32'd0,        4'b1011, 1, 32'hFFFFF0F0, 3'b000, 0, 0);
        vecs[10] = mk(0, 0, 3'b111, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        4'b1101, 1, 32'hF000F000, 3'b000, 0, 0);
        vecs[11] = mk(1, 0, 3'b101, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0001, 1, 32'd0,        3'b000, 0, 0);
        vecs[12] = mk(1, 0, 3'b111, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0010, 1, 32'd0,        3'b000, 1, 0);
        vecs[13] = mk(1, 0, 3'b000, 0, 32'h1234,     32'h1234,     32'd0,        4'b0000, 1, 32'd0,        3'b000, 1, 0);
        vecs[14] = mk(1, 0, 3'b001, 0, 32'h1234,     32'h1234,     32'd0,        4'b0000, 1, 32'd0,        3'b000, 0, 0);
        vecs[15] = mk(1, 0, 3'b100, 0, 32'hFFFFFFFE, 32'd3,        32'd0,        4'b0001, 1, 32'd0,        3'b000, 1, 0);
        vecs[16] = mk(1, 1, 3'b110, 0, 32'd3,        32'hFFFFFFFE, 32'd7,        4'b0010, 1, 32'd0,        3'b000, 1, 0);
        vecs[17] = mk(0, 0, 3'b100, 1, 32'd5,        32'd7,        32'd0,        4'b0101, 1, 32'd0,        3'b000, 0, 1);
        vecs[18] = mk(0, 1, 3'b001, 1, 32'd5,        32'd0,        32'h00000403, 4'b0101, 1, 32'd0,        3'b000, 0, 1);
        vecs[19] = mk(1, 0, 3'b010, 0, 32'd0,        32'd0,        32'd0,        4'b0000, 0, 32'd0,        3'b000, 0, 1);
        vecs[20] = mk(0, 1, 3'b100, 1, 32'd0,        32'd0,        32'hFFFFFC00, 4'b1100, 1, 32'hFFFFFC00, 3'b000, 0, 0);
        vecs[21] = mk(0, 0, 3'b000, 1, 32'd7,        32'd5,        32'd0,        4'b0111, 1, 32'd2,        3'b100, 0, 0);
        vecs[22] = mk(0, 0, 3'b101, 1, 32'hF0000000, 32'd8,        32'd0,        4'b1010, 1, 32'hFFF00000, 3'b000, 0, 0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_is_branch = 1'b0; in_is_imm = 1'b0; in_funct3 = 3'd0; in_funct7_b5 = 1'b0;
        in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 0, 32'(out_valid), 32'd0);
        check("rst_in_ready", 0, 32'(in_ready), 32'd1);
        check("rst_alu_cntrl", 0, 32'(alu_cntrl), 32'h5);
        check("rst_alu_a", 0, alu_a, 32'd0);
        check("rst_alu_b", 0, alu_b, 32'd0);
        check("rst_alu_cin", 0, 32'(alu_cin), 32'd0);
        check("rst_out_result", 0, out_result, 32'd0);
        check("rst_out_flags", 0, 32'(out_flags), 32'd0);
        @(posedge clk); #1;

        // Full table back-to-back with the consumer always ready: no stalls allowed.
        tot = 0;
        for (int i = 0; i < NV; i++) begin
            send(vecs[i], i, st);
            tot += st;
        end
        check("throughput_stalls", 0, 32'(tot), 32'd0);
        drain("drain_table");

        // Four ops with the consumer stalled mid-stream.
        saw_stall  = 1'b0;
        out_before = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(vecs[i], 100 + i, st);
                end
            end
            begin
                @(posedge clk); @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("bp_in_ready_dropped", 0, 32'(saw_stall), 32'd1);
        check("bp_out_count", 0, 32'(n_out - out_before), 32'd4);
        check("bp_alu_cin", 0, 32'(alu_cin), 32'd0);

        // Reset with one op held at the output and one in stage 1.
        out_ready = 1'b0;
        send(vecs[8], 200, st);
        send(vecs[9], 201, st);
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 0, 32'(out_valid), 32'd0);
        check("midrst_alu_cntrl", 0, 32'(alu_cntrl), 32'h5);
        out_ready  = 1'b1;
        out_before = n_out;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_retire", 0, 32'(n_out - out_before), 32'd0);
        check("midrst_out_valid_late", 0, 32'(out_valid), 32'd0);

        // Stream resumes cleanly after reset.
        send(vecs[0], 300, st);
        send(vecs[12], 301, st);
        drain("drain_post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
